adc_sampler: RTL and testbench

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/oscope_pkg.sv | 22 ++
 rtl/adc_clk_gen.sv | 35 +++
 rtl/adc_sampler.sv | 130 +++++++++++++
 tb/tb_adc_sampler.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oscope_pkg.sv
// oscope_pkg: shared FSM state type and default parameters
// for the serial ADC sampler front end.
package oscope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } samp_state_t;

    localparam int DEF_CLK_DIV    = 64;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_LEAD_PAD   = 2;
    localparam int DEF_DATA_BITS  = 8;

    localparam logic [15:0] OVR_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == OVR_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// adc_clk_gen: divides osc_clk down to the ADC serial clock and
// flags the osc_clk cycle on which adc_clk is about to rise.
module adc_clk_gen
    import oscope_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic osc_clk,
    input  logic reset,
    output logic adc_clk,
    output logic rise_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap      = (div_cnt == LAST);
    assign rise_tick = wrap & ~adc_clk;

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: clocks frames out of a serial ADC, extracts the data
// field, decimates frames and hands samples over a valid/ready port.
module adc_sampler
    import oscope_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int LEAD_PAD   = DEF_LEAD_PAD,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 osc_clk,
    input  logic                 reset,
    input  logic                 adc_data,
    input  logic                 enable,
    input  logic [7:0]           decim,
    input  logic                 sample_ready,
    output logic                 adc_clk,
    output logic                 adc_conv,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    output logic                 busy,
    output logic [15:0]          overrun_count
);

    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam int WORD_MSB = FRAME_BITS - 1 - LEAD_PAD;

    samp_state_t           state;
    logic                  rise_tick;
    logic [BW-1:0]         bitcnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  frame_end;
    logic [7:0]            dcnt;
    logic                  deliver;
    logic                  accept;
    logic [DATA_BITS-1:0]  word;

    adc_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .osc_clk  (osc_clk),
        .reset    (reset),
        .adc_clk  (adc_clk),
        .rise_tick(rise_tick)
    );

    assign word    = shift_reg[WORD_MSB -: DATA_BITS];
    assign deliver = frame_end && (dcnt == decim);
    assign accept  = sample_valid && sample_ready;

    // Frame sequencer; every transition is aligned to an adc_clk rise.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            adc_conv  <= 1'b1;
            busy      <= 1'b0;
            bitcnt    <= '0;
            shift_reg <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (rise_tick) begin
                unique case (state)
                    ST_IDLE: begin
                        if (enable) begin
                            state    <= ST_SHIFT;
                            adc_conv <= 1'b0;
                            busy     <= 1'b1;
                            bitcnt   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        shift_reg <= FRAME_BITS'({shift_reg, adc_data});
                        bitcnt    <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            state     <= ST_DONE;
                            adc_conv  <= 1'b1;
                            frame_end <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (enable) begin
                            state    <= ST_SHIFT;
                            adc_conv <= 1'b0;
                            bitcnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        adc_conv <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A shrunk decim can leave dcnt above it; that frame is skipped.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (frame_end) begin
            if (dcnt >= decim) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            sample_data   <= '0;
            sample_valid  <= 1'b0;
            overrun_count <= '0;
        end else if (deliver && (!sample_valid || sample_ready)) begin
            sample_data  <= word;
            sample_valid <= 1'b1;
        end else if (deliver) begin
            overrun_count <= sat_inc16(overrun_count);
        end else if (accept) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: randomized frames from a behavioural serial ADC,
// checked against word/decimation/handshake rules.
module tb_adc_sampler;

    localparam int CLK_DIV   = 2;
    localparam int FB        = 16;
    localparam int LP        = 2;
    localparam int DB        = 8;
    localparam int FRAME_CYC = (FB + 1) * 2 * CLK_DIV;

    logic          osc_clk = 1'b0;
    logic          reset = 1'b1;
    logic          adc_data = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    decim = 8'd0;
    logic          sample_ready = 1'b0;
    logic          adc_clk;
    logic          adc_conv;
    logic [DB-1:0] sample_data;
    logic          sample_valid;
    logic          busy;
    logic [15:0]   overrun_count;

    int n_cmp = 0;
    int n_bad = 0;

    int          cyc = 0;
    logic [15:0] words[$];
    logic [15:0] fin[$];
    logic [7:0]  got[$];
    int          xfer_t[$];
    logic [15:0] cur_word = 16'h0;
    int          idx = 0;
    int          last_len = 0;
    int          frames_started = 0;
    int          frames_done = 0;
    bit          in_frame = 0;
    logic        prev_clk = 1'b0;
    logic        prev_conv = 1'b1;

    adc_sampler #(
        .CLK_DIV   (CLK_DIV),
        .FRAME_BITS(FB),
        .LEAD_PAD  (LP),
        .DATA_BITS (DB)
    ) dut (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .adc_data     (adc_data),
        .enable       (enable),
        .decim        (decim),
        .sample_ready (sample_ready),
        .adc_clk      (adc_clk),
        .adc_conv     (adc_conv),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun_count(overrun_count)
    );

    always #5 osc_clk = ~osc_clk;

    function automatic logic [7:0] extract(input logic [15:0] w);
        return 8'((w >> (FB - LP - DB)) & 16'h00FF);
    endfunction

    // Serial ADC model plus transfer observer, run mid low-phase.
    always begin
        @(negedge osc_clk);
        #2;
        cyc++;
        if (reset) begin
            in_frame = 0;
            idx = 0;
        end else begin
            if (prev_conv && !adc_conv) begin
                cur_word = (words.size() > 0) ? words.pop_front()
                                              : 16'($urandom);
                idx = 0;
                in_frame = 1;
                frames_started++;
            end else if (in_frame && !prev_clk && adc_clk && !prev_conv) begin
                idx++;
            end
            if (in_frame && !prev_conv && adc_conv) begin
                in_frame = 0;
                last_len = idx;
                if (idx == FB) begin
                    fin.push_back(cur_word);
                    frames_done++;
                end
            end
            if (sample_valid && sample_ready) begin
                got.push_back(sample_data);
                xfer_t.push_back(cyc);
            end
        end
        adc_data = (in_frame && idx < FB) ? cur_word[FB-1-idx] : 1'b0;
        prev_clk = adc_clk;
        prev_conv = adc_conv;
    end

    task automatic tick();
        @(negedge osc_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        words.delete();
        fin.delete();
        got.delete();
        xfer_t.delete();
        frames_started = 0;
        frames_done = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int n, input int lim, output bit ok);
        for (int i = 0; i < lim && frames_done < n; i++) tick();
        ok = (frames_done >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (adc_clk !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_adc_clk: got %b want 0", adc_clk);
        end
        n_cmp++;
        if (adc_conv !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_adc_conv: got %b want 1", adc_conv);
        end
        n_cmp++;
        if (sample_valid !== 1'b0 || sample_data !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_sample: got v=%b d=%h want v=0 d=00",
                     sample_valid, sample_data);
        end
        n_cmp++;
        if (busy !== 1'b0 || overrun_count !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_busy_ovr: got b=%b o=%h want 0/0000",
                     busy, overrun_count);
        end
    endtask

    task automatic test_single_frame();
        int t_fall = -1;
        int t_rise = -1;
        int t_val = -1;
        bit busy_ok = 1;
        logic pc;
        enable = 1'b1;
        decim = 8'd0;
        sample_ready = 1'b0;
        apply_reset();
        words.push_back(16'h2AC0);
        pc = adc_conv;
        for (int i = 0; i < 400 && t_val < 0; i++) begin
            tick();
            if (!adc_conv && !busy) busy_ok = 0;
            if (pc && !adc_conv && t_fall < 0) t_fall = i;
            if (!pc && adc_conv && t_rise < 0) t_rise = i;
            if (sample_valid && t_val < 0) t_val = i;
            pc = adc_conv;
        end
        enable = 1'b0;
        n_cmp++;
        if (t_val < 0) begin
            n_bad++;
            $display("FAIL single_timeout: no sample_valid in 400 cycles");
        end
        n_cmp++;
        if (sample_data !== 8'hAB) begin
            n_bad++;
            $display("FAIL single_data: got %h want ab", sample_data);
        end
        n_cmp++;
        if (t_rise - t_fall != FB * 2 * CLK_DIV) begin
            n_bad++;
            $display("FAIL single_conv_low: got %0d want %0d cycles",
                     t_rise - t_fall, FB * 2 * CLK_DIV);
        end
        n_cmp++;
        if (t_val - t_rise != 1) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want 1", t_val - t_rise);
        end
        n_cmp++;
        if (last_len != FB) begin
            n_bad++;
            $display("FAIL single_rises: got %0d want %0d", last_len, FB);
        end
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy: got busy=0 with adc_conv low want 1");
        end
    endtask

    task automatic test_continuous();
        bit ok;
        enable = 1'b1;
        decim = 8'd0;
        sample_ready = 1'b1;
        apply_reset();
        words.push_back(16'h3FC0);
        words.push_back(16'h3FC0);
        wait_done(5, 6 * FRAME_CYC, ok);
        repeat (4) tick();
        enable = 1'b0;
        n_cmp++;
        if (!ok || got.size() < 5) begin
            n_bad++;
            $display("FAIL cont_count: got %0d want 5", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== 8'hFF) begin
                n_bad++;
                $display("FAIL cont_ff: got %h want ff", got[0]);
            end
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got[i] !== extract(fin[i])) begin
                    n_bad++;
                    $display("FAIL cont_word%0d: got %h want %h",
                             i, got[i], extract(fin[i]));
                end
            end
            for (int i = 1; i < 5; i++) begin
                n_cmp++;
                if (xfer_t[i] - xfer_t[i-1] != FRAME_CYC) begin
                    n_bad++;
                    $display("FAIL cont_period%0d: got %0d want %0d",
                             i, xfer_t[i] - xfer_t[i-1], FRAME_CYC);
                end
            end
        end
        n_cmp++;
        if (overrun_count !== 16'h0) begin
            n_bad++;
            $display("FAIL cont_ovr: got %0d want 0", overrun_count);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        enable = 1'b1;
        decim = 8'd0;
        sample_ready = 1'b0;
        apply_reset();
        wait_done(3, 4 * FRAME_CYC, ok);
        repeat (3) tick();
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL ovr_timeout: got %0d frames want 3", frames_done);
        end
        n_cmp++;
        if (sample_valid !== 1'b1 || sample_data !== extract(fin[0])) begin
            n_bad++;
            $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=%h",
                     sample_valid, sample_data, extract(fin[0]));
        end
        n_cmp++;
        if (overrun_count !== 16'd2) begin
            n_bad++;
            $display("FAIL ovr_count: got %0d want 2", overrun_count);
        end
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_accept: got valid=%b want 0", sample_valid);
        end
        wait_done(4, 2 * FRAME_CYC, ok);
        repeat (3) tick();
        enable = 1'b0;
        n_cmp++;
        if (!ok || sample_valid !== 1'b1 || sample_data !== extract(fin[3])) begin
            n_bad++;
            $display("FAIL ovr_next: got v=%b d=%h want v=1 d=%h",
                     sample_valid, sample_data, extract(fin[fin.size()-1]));
        end
        n_cmp++;
        if (overrun_count !== 16'd2) begin
            n_bad++;
            $display("FAIL ovr_count2: got %0d want 2", overrun_count);
        end
    endtask

    task automatic test_decim();
        bit ok;
        int dv[2];
        logic [7:0] exp_q[$];
        dv[0] = 3;
        dv[1] = int'($urandom_range(0, 2));
        for (int r = 0; r < 2; r++) begin
            enable = 1'b1;
            decim = 8'(dv[r]);
            sample_ready = 1'b1;
            apply_reset();
            wait_done(8, 10 * FRAME_CYC, ok);
            repeat (4) tick();
            enable = 1'b0;
            exp_q.delete();
            for (int k = 0; k < fin.size() && k < 8; k++)
                if ((k + 1) % (dv[r] + 1) == 0) exp_q.push_back(extract(fin[k]));
            n_cmp++;
            if (!ok || got.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL decim%0d_count: got %0d want %0d",
                         dv[r], got.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_cmp++;
                    if (got[k] !== exp_q[k]) begin
                        n_bad++;
                        $display("FAIL decim%0d_word%0d: got %h want %h",
                                 dv[r], k, got[k], exp_q[k]);
                    end
                end
            end
            if (r == 0) begin
                n_cmp++;
                if (got.size() != 2) begin
                    n_bad++;
                    $display("FAIL decim3_two: got %0d want 2", got.size());
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int i;
        enable = 1'b1;
        decim = 8'd0;
        sample_ready = 1'b0;
        apply_reset();
        for (i = 0; i < 4 * FRAME_CYC; i++) begin
            if (frames_started == 2 && idx == 7) break;
            tick();
        end
        n_cmp++;
        if (frames_started != 2 || idx != 7) begin
            n_bad++;
            $display("FAIL mid_timeout: got frame %0d bit %0d want 2/7",
                     frames_started, idx);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (adc_clk !== 1'b0 || adc_conv !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_ctrl: got clk=%b conv=%b busy=%b want 0/1/0",
                     adc_clk, adc_conv, busy);
        end
        n_cmp++;
        if (sample_valid !== 1'b0 || sample_data !== 8'h00 ||
            overrun_count !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_out: got v=%b d=%h o=%h want 0/00/0000",
                     sample_valid, sample_data, overrun_count);
        end
        repeat (4) tick();
        fin.delete();
        got.delete();
        frames_started = 0;
        frames_done = 0;
        sample_ready = 1'b1;
        tick();
        reset = 1'b0;
        wait_done(1, 2 * FRAME_CYC, ok);
        repeat (3) tick();
        enable = 1'b0;
        n_cmp++;
        if (!ok || got.size() != 1) begin
            n_bad++;
            $display("FAIL mid_clean_count: got %0d want 1", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== extract(fin[0])) begin
                n_bad++;
                $display("FAIL mid_clean_word: got %h want %h",
                         got[0], extract(fin[0]));
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int i;
        enable = 1'b1;
        decim = 8'd0;
        sample_ready = 1'b1;
        apply_reset();
        for (i = 0; i < 2 * FRAME_CYC; i++) begin
            if (frames_started == 1 && idx == 5) break;
            tick();
        end
        enable = 1'b0;
        wait_done(1, 2 * FRAME_CYC, ok);
        repeat (3) tick();
        n_cmp++;
        if (!ok || got.size() != 1) begin
            n_bad++;
            $display("FAIL drop_count: got %0d want 1", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== extract(fin[0])) begin
                n_bad++;
                $display("FAIL drop_word: got %h want %h",
                         got[0], extract(fin[0]));
            end
        end
        repeat (4 * CLK_DIV) tick();
        n_cmp++;
        if (adc_conv !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_idle: got conv=%b busy=%b want 1/0",
                     adc_conv, busy);
        end
        repeat (3 * FRAME_CYC) tick();
        n_cmp++;
        if (frames_started != 1) begin
            n_bad++;
            $display("FAIL drop_restart: got %0d frames want 1",
                     frames_started);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_overrun();
        test_decim();
        test_reset_midframe();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
